// File: rtl/btn_debounce_rpt_if.sv
// rtl/btn_debounce_rpt_if.sv - button pins and conditioned button outputs
interface btn_debounce_rpt_if #(
   parameter int N = 4
);
   logic [N-1:0] nBIN;
   logic         TICK;
   logic [N-1:0] BLEVEL;
   logic [N-1:0] BPRESS;
   logic [N-1:0] BRELEASE;
   logic [N-1:0] BREPEAT;

   modport master (
      output nBIN,
      input  TICK, BLEVEL, BPRESS, BRELEASE, BREPEAT
   );

   modport slave (
      input  nBIN,
      output TICK, BLEVEL, BPRESS, BRELEASE, BREPEAT
   );
endinterface

// File: rtl/btn_debounce_rpt.sv
// rtl/btn_debounce_rpt.sv - N-channel button synchroniser, debouncer and auto-repeat
module btn_debounce_rpt #(
   parameter int N          = 4,
   parameter int TICK_DIV   = 1250000,
   parameter int STABLE_CNT = 2,
   parameter int ACTIVE_LOW = 1,
   parameter int REPEAT_EN  = 1,
   parameter int REPEAT_DLY = 20,
   parameter int REPEAT_PER = 4
) (
   input logic              CLK,
   input logic              nRST,
   btn_debounce_rpt_if.slave bus
);
   localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TMAX = CW'(TICK_DIV - 1);
   localparam int            SW   = $clog2(STABLE_CNT + 1);
   localparam logic [SW-1:0] SMAX = SW'(STABLE_CNT - 1);
   localparam logic [N-1:0]  IDLE = {N{ACTIVE_LOW != 0}};

   logic [CW-1:0] tcnt;
   logic          tick;
   logic [N-1:0]  sync1, sync2, s;
   logic [N-1:0]  lvl_q, lvl_d;
   logic [N-1:0]  prs_q, prs_d;
   logic [N-1:0]  rel_q, rel_d;
   logic [N-1:0]  rpt_q, rpt_d;
   logic [SW-1:0] stab_q [N];
   logic [SW-1:0] stab_d [N];

   assign tick = (tcnt == TMAX);
   assign s    = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         tcnt <= '0;
      end else if (tick) begin
         tcnt <= '0;
      end else begin
         tcnt <= tcnt + CW'(1);
      end
   end

   // Sync FFs reset to the idle pin level so releasing reset never fakes a press.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         sync1 <= IDLE;
         sync2 <= IDLE;
      end else begin
         sync1 <= bus.nBIN;
         sync2 <= sync1;
      end
   end

   always_comb begin
      lvl_d  = lvl_q;
      prs_d  = '0;
      rel_d  = '0;
      stab_d = stab_q;
      if (tick) begin
         for (int i = 0; i < N; i++) begin
            if (s[i] == lvl_q[i]) begin
               stab_d[i] = '0;
            end else if (stab_q[i] == SMAX) begin
               lvl_d[i]  = s[i];
               stab_d[i] = '0;
               prs_d[i]  = s[i];
               rel_d[i]  = ~s[i];
            end else begin
               stab_d[i] = stab_q[i] + SW'(1);
            end
         end
      end
   end

   generate
      if (REPEAT_EN != 0) begin : g_rpt
         localparam int            HMAX  = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
         localparam int            HW    = $clog2(HMAX + 1);
         localparam logic [HW-1:0] DLY_V = HW'(REPEAT_DLY);
         localparam logic [HW-1:0] PER_V = HW'(REPEAT_PER);

         logic [HW-1:0] hold_q [N];
         logic [HW-1:0] hold_d [N];
         logic [N-1:0]  first_q, first_d;

         // A release on the same tick wins over a due repeat.
         always_comb begin
            rpt_d   = '0;
            hold_d  = hold_q;
            first_d = first_q;
            if (tick) begin
               for (int i = 0; i < N; i++) begin
                  if (prs_d[i]) begin
                     rpt_d[i]   = 1'b1;
                     hold_d[i]  = '0;
                     first_d[i] = 1'b0;
                  end else if (lvl_q[i] && !rel_d[i]) begin
                     if ((hold_q[i] + HW'(1)) == (first_q[i] ? PER_V : DLY_V)) begin
                        rpt_d[i]   = 1'b1;
                        hold_d[i]  = '0;
                        first_d[i] = 1'b1;
                     end else begin
                        hold_d[i] = hold_q[i] + HW'(1);
                     end
                  end else begin
                     hold_d[i]  = '0;
                     first_d[i] = 1'b0;
                  end
               end
            end
         end

         always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
               for (int i = 0; i < N; i++) begin
                  hold_q[i] <= '0;
               end
               first_q <= '0;
            end else begin
               hold_q  <= hold_d;
               first_q <= first_d;
            end
         end
      end else begin : g_norpt
         assign rpt_d = prs_d;
      end
   endgenerate

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         lvl_q <= '0;
         prs_q <= '0;
         rel_q <= '0;
         rpt_q <= '0;
         for (int i = 0; i < N; i++) begin
            stab_q[i] <= '0;
         end
      end else begin
         lvl_q  <= lvl_d;
         prs_q  <= prs_d;
         rel_q  <= rel_d;
         rpt_q  <= rpt_d;
         stab_q <= stab_d;
      end
   end

   assign bus.TICK     = tick;
   assign bus.BLEVEL   = lvl_q;
   assign bus.BPRESS   = prs_q;
   assign bus.BRELEASE = rel_q;
   assign bus.BREPEAT  = rpt_q;
endmodule

// File: tb/tb_btn_debounce_rpt.sv
// tb/tb_btn_debounce_rpt.sv - scoreboard bench for btn_debounce_rpt
module tb_btn_debounce_rpt;
   logic CLK;
   logic nRST;

   btn_debounce_rpt_if #(.N(4)) bus ();

   btn_debounce_rpt #(
      .N(4), .TICK_DIV(4), .STABLE_CNT(3), .ACTIVE_LOW(1),
      .REPEAT_EN(1), .REPEAT_DLY(5), .REPEAT_PER(2)
   ) dut (
      .CLK (CLK),
      .nRST(nRST),
      .bus (bus)
   );

   typedef struct {
      int         tag;
      logic [3:0] prs;
      logic [3:0] rel;
      logic [3:0] rpt;
      logic [3:0] lvl;
   } ev_t;

   ev_t        q[$];
   logic [3:0] lvl_model;
   int         n_chk  = 0;
   int         n_pass = 0;
   int         cyc    = 0;
   int         tick_no = 0;
   logic [3:0] prev_lvl = '0;
   logic       prev_tick = 1'b0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic push(input int tag, input logic [3:0] p, input logic [3:0] r, input logic [3:0] rp);
      ev_t e;
      lvl_model = (lvl_model | p) & ~r;
      e.tag = tag;
      e.prs = p;
      e.rel = r;
      e.rpt = rp;
      e.lvl = lvl_model;
      q.push_back(e);
   endtask

   // Returns inside a tick cycle; t is that tick's number since reset.
   task automatic at_tick(output int t);
      do begin
         @(posedge CLK);
         #1;
      end while (cyc % 4 != 3);
      t = tick_no + 1;
   endtask

   task automatic wait_to(input int target);
      int t;
      do at_tick(t); while (t < target);
   endtask

   always @(negedge CLK) begin
      logic exp_t;
      ev_t  e;
      if (!nRST) begin
         cyc       = 0;
         tick_no   = 0;
         prev_lvl  = bus.BLEVEL;
         prev_tick = 1'b0;
      end else begin
         exp_t = (cyc % 4 == 3);
         chk("tick", int'(bus.TICK), int'(exp_t));
         if (bus.BLEVEL != prev_lvl) chk("blevel_after_tick", int'(prev_tick), 1);
         while (q.size() > 0 && q[0].tag < tick_no) begin
            e = q.pop_front();
            chk("missed_pulse", tick_no, e.tag);
         end
         if ((bus.BPRESS | bus.BRELEASE | bus.BREPEAT) != 4'h0) begin
            if (q.size() == 0) begin
               chk("unexpected_pulse", int'({bus.BPRESS, bus.BRELEASE, bus.BREPEAT}), 0);
            end else begin
               e = q.pop_front();
               chk("pulse_tick", tick_no, e.tag);
               chk("pulse_bits", int'({bus.BPRESS, bus.BRELEASE, bus.BREPEAT, bus.BLEVEL}),
                   int'({e.prs, e.rel, e.rpt, e.lvl}));
            end
         end
         prev_lvl  = bus.BLEVEL;
         prev_tick = exp_t;
         if (exp_t) tick_no++;
         cyc++;
      end
   end

   initial begin
      int t;
      int p;
      lvl_model = '0;
      bus.nBIN  = 4'hF;
      nRST      = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_outputs", int'({bus.TICK, bus.BLEVEL, bus.BPRESS, bus.BRELEASE, bus.BREPEAT}), 0);
      nRST = 1'b1;

      // single press, one repeat, release before the second repeat
      at_tick(t);
      bus.nBIN[0] = 1'b0;
      push(t + 3, 4'b0001, 4'b0000, 4'b0001);
      push(t + 8, 4'b0000, 4'b0000, 4'b0001);
      wait_to(t + 6);
      bus.nBIN[0] = 1'b1;
      push(t + 9, 4'b0000, 4'b0001, 4'b0000);
      wait_to(t + 12);

      // bounce shorter than three ticks never changes the level
      at_tick(t);
      repeat (10) begin
         bus.nBIN[1] = ~bus.nBIN[1];
         repeat (6) @(posedge CLK);
         #1;
      end
      at_tick(t);
      wait_to(t + 5);
      chk("bounce_level", int'(bus.BLEVEL[1]), 0);

      // long hold: repeats at P+5 then every 2 ticks
      at_tick(t);
      bus.nBIN[2] = 1'b0;
      p = t + 3;
      push(p, 4'b0100, 4'b0000, 4'b0100);
      for (int k = 5; k < 20; k += 2) push(p + k, 4'b0000, 4'b0000, 4'b0100);
      wait_to(t + 20);
      bus.nBIN[2] = 1'b1;
      push(p + 20, 4'b0000, 4'b0100, 4'b0000);
      wait_to(p + 26);

      // two channels together; release lands on the tick a repeat would be due
      at_tick(t);
      bus.nBIN[3:2] = 2'b00;
      push(t + 3, 4'b1100, 4'b0000, 4'b1100);
      wait_to(t + 5);
      bus.nBIN[3:2] = 2'b11;
      push(t + 8, 4'b0000, 4'b1100, 4'b0000);
      wait_to(t + 12);

      // reset while pressed, button held through reset
      at_tick(t);
      bus.nBIN[0] = 1'b0;
      push(t + 3, 4'b0001, 4'b0000, 4'b0001);
      wait_to(t + 4);
      chk("level_before_reset", int'(bus.BLEVEL[0]), 1);
      nRST = 1'b0;
      #1;
      chk("reset_clears", int'({bus.TICK, bus.BLEVEL, bus.BPRESS, bus.BRELEASE, bus.BREPEAT}), 0);
      chk("queue_at_reset", q.size(), 0);
      lvl_model = '0;
      repeat (2) @(posedge CLK);
      #1;
      nRST = 1'b1;
      push(3, 4'b0001, 4'b0000, 4'b0001);
      wait_to(4);
      bus.nBIN[0] = 1'b1;
      push(7, 4'b0000, 4'b0001, 4'b0000);
      wait_to(10);

      for (int i = 0; i < 100; i++) begin
         if (q.size() == 0) break;
         @(posedge CLK);
      end
      chk("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
